// File: rtl/pending_event_encoder_pkg.sv
// Shared sizes, state encoding and helpers for the pending event encoder.
package pending_event_encoder_pkg;
  localparam int N_REQ = 32;
  localparam int IDX_W = 5;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] VALID = 1'b1;

  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/pick_encoder_32to5.sv
// Combinational 32-to-5 picker: lowest set bit at or above base (rr=1) or from bit 0 (rr=0).
module pick_encoder_32to5
  import pending_event_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] base,
  input  logic             rr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] shift;
  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] enc;

  always_comb begin
    shift = rr ? base : '0;
    // Rotate so that bit 'shift' lands at position 0; a shift of 32 yields zero.
    rot = (cand >> shift) | (cand << (6'd32 - {1'b0, shift}));
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = i[IDX_W-1:0];
    end
    idx = enc + shift;
    any = |cand;
  end

endmodule

// File: rtl/pending_event_encoder.sv
// Sticky request latch with one-at-a-time index dispatch over a valid/ready handshake.
module pending_event_encoder
  import pending_event_encoder_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req_in,
  input  logic             clr_all,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             dup
);

  localparam logic RR = (ROUND_ROBIN != 0);

  logic [0:0]       state;
  logic [IDX_W-1:0] ptr;
  logic             accept;
  logic [N_REQ-1:0] set;
  logic [N_REQ-1:0] clear;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] sel;
  logic             any;

  assign out_valid = (state == VALID);
  assign accept    = out_valid & out_ready;
  assign set       = req_in & {N_REQ{en}};
  assign clear     = accept ? idx_onehot(out_idx) : '0;
  // Selection sees only registered pending bits; this cycle's requests wait a cycle.
  assign cand      = pending & ~clear;

  pick_encoder_32to5 u_pick (
    .cand (cand),
    .base (ptr),
    .rr   (RR),
    .idx  (sel),
    .any  (any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      state   <= EMPTY;
      out_idx <= '0;
      dup     <= 1'b0;
      ptr     <= '0;
    end else if (clr_all) begin
      pending <= '0;
      state   <= EMPTY;
      dup     <= 1'b0;
    end else begin
      pending <= (pending & ~clear) | set;
      dup     <= |(set & pending & ~clear);
      if (RR && accept) ptr <= out_idx + 5'd1;
      if (state == EMPTY) begin
        if (any) begin
          out_idx <= sel;
          state   <= VALID;
        end
      end else if (out_ready) begin
        if (any) out_idx <= sel;
        else     state   <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_pending_event_encoder.sv
// Bench for pending_event_encoder: fixed-priority and round-robin instances on shared stimulus.
module tb_pending_event_encoder;

  logic        clock;
  logic        reset;
  logic        en;
  logic [31:0] req_in;
  logic        clr_all;
  logic        out_ready;

  logic        fp_out_valid, rr_out_valid;
  logic [4:0]  fp_out_idx,   rr_out_idx;
  logic [31:0] fp_pending,   rr_pending;
  logic        fp_dup,       rr_dup;

  int n_cmp;
  int n_bad;
  logic [4:0] q_f[$];
  logic [4:0] q_r[$];

  pending_event_encoder #(.ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset(reset), .en(en), .req_in(req_in), .clr_all(clr_all),
    .out_ready(out_ready), .out_valid(fp_out_valid), .out_idx(fp_out_idx),
    .pending(fp_pending), .dup(fp_dup)
  );

  pending_event_encoder #(.ROUND_ROBIN(1)) dut_rr (
    .clock(clock), .reset(reset), .en(en), .req_in(req_in), .clr_all(clr_all),
    .out_ready(out_ready), .out_valid(rr_out_valid), .out_idx(rr_out_idx),
    .pending(rr_pending), .dup(rr_dup)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; req_in = '0; clr_all = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    q_f.delete();
    q_r.delete();
  endtask

  task automatic test_reset();
    n_cmp++; if (fp_out_valid !== 1'b0 || fp_pending !== 32'h0 || fp_out_idx !== 5'd0 || fp_dup !== 1'b0) begin
      n_bad++; $display("FAIL reset_state_fp: valid=%b pending=%h idx=%0d dup=%b, required all zero", fp_out_valid, fp_pending, fp_out_idx, fp_dup); end
    n_cmp++; if (rr_out_valid !== 1'b0 || rr_pending !== 32'h0 || rr_out_idx !== 5'd0 || rr_dup !== 1'b0) begin
      n_bad++; $display("FAIL reset_state_rr: valid=%b pending=%h idx=%0d dup=%b, required all zero", rr_out_valid, rr_pending, rr_out_idx, rr_dup); end
    reset = 1'b0;
    en = 1'b1; req_in = 32'h0000_0006;
    step();
    req_in = '0;
    step();
    n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== 5'd1) begin
      n_bad++; $display("FAIL pre_reset_present: valid=%b idx=%0d, required 1/1", fp_out_valid, fp_out_idx); end
    reset = 1'b1;
    #1;
    n_cmp++; if (fp_out_valid !== 1'b0 || fp_pending !== 32'h0 || fp_out_idx !== 5'd0 || fp_dup !== 1'b0) begin
      n_bad++; $display("FAIL midrun_reset: valid=%b pending=%h idx=%0d dup=%b, required all zero", fp_out_valid, fp_pending, fp_out_idx, fp_dup); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [4:0] e;
    en = 1'b1; out_ready = 1'b0; req_in = 32'h0000_0100;
    q_f.push_back(5'd8);
    step();
    req_in = '0;
    n_cmp++; if (fp_pending !== 32'h0000_0100 || fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_capture: pending=%h valid=%b, required 00000100/0", fp_pending, fp_out_valid); end
    step();
    e = q_f.pop_front();
    n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== e) begin
      n_bad++; $display("FAIL single_present: valid=%b idx=%0d, required 1/%0d", fp_out_valid, fp_out_idx, e); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== e) begin
        n_bad++; $display("FAIL single_stall%0d: valid=%b idx=%0d, required 1/%0d", k, fp_out_valid, fp_out_idx, e); end
    end
    out_ready = 1'b1;
    step();
    n_cmp++; if (fp_pending !== 32'h0 || fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_accept: pending=%h valid=%b, required 0/0", fp_pending, fp_out_valid); end
    step();
    n_cmp++; if (fp_pending !== 32'h0 || fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ready_while_idle: pending=%h valid=%b, required 0/0", fp_pending, fp_out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_fixed_burst();
    logic [4:0] e;
    do_reset();
    en = 1'b1; out_ready = 1'b1; req_in = 32'h8000_0015;
    q_f.push_back(5'd0); q_f.push_back(5'd2); q_f.push_back(5'd4); q_f.push_back(5'd31);
    step();
    req_in = '0;
    n_cmp++; if (fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL burst_latency: valid=%b one edge after request, required 0", fp_out_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      e = q_f.pop_front();
      n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== e) begin
        n_bad++; $display("FAIL burst_grant%0d: valid=%b idx=%0d, required 1/%0d", k, fp_out_valid, fp_out_idx, e); end
    end
    step();
    n_cmp++; if (fp_out_valid !== 1'b0 || fp_pending !== 32'h0) begin
      n_bad++; $display("FAIL burst_end: valid=%b pending=%h, required 0/0", fp_out_valid, fp_pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [4:0] e;
    do_reset();
    en = 1'b1; req_in = 32'h0000_0400;
    step();
    req_in = '0;
    step();
    n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_idx !== 5'd10) begin
      n_bad++; $display("FAIL rr_first: valid=%b idx=%0d, required 1/10", rr_out_valid, rr_out_idx); end
    req_in = 32'h0000_0008;
    step();
    // accept 10 while re-requesting it; 3 comes next, 10 stays pending
    out_ready = 1'b1; req_in = 32'h0000_0400;
    q_r.push_back(5'd3);
    step();
    out_ready = 1'b0; req_in = '0;
    e = q_r.pop_front();
    n_cmp++; if (rr_out_idx !== e || rr_pending !== 32'h0000_0408 || rr_dup !== 1'b0) begin
      n_bad++; $display("FAIL rr_after10: idx=%0d pending=%h dup=%b, required %0d/00000408/0", rr_out_idx, rr_pending, rr_dup, e); end
    step();
    out_ready = 1'b1;
    q_r.push_back(5'd10);
    step();
    out_ready = 1'b0;
    e = q_r.pop_front();
    n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_idx !== e) begin
      n_bad++; $display("FAIL rr_rerequest: valid=%b idx=%0d, required 1/%0d", rr_out_valid, rr_out_idx, e); end
    req_in = 32'hC000_0001;
    step();
    req_in = '0;
    out_ready = 1'b1;
    q_r.push_back(5'd30); q_r.push_back(5'd31); q_r.push_back(5'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      e = q_r.pop_front();
      n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_idx !== e) begin
        n_bad++; $display("FAIL rr_wrap%0d: valid=%b idx=%0d, required 1/%0d", k, rr_out_valid, rr_out_idx, e); end
    end
    step();
    n_cmp++; if (rr_out_valid !== 1'b0 || rr_pending !== 32'h0) begin
      n_bad++; $display("FAIL rr_end: valid=%b pending=%h, required 0/0", rr_out_valid, rr_pending); end
    out_ready = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    en = 1'b1; req_in = 32'h0000_0020;
    step();
    req_in = '0;
    step();
    n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== 5'd5) begin
      n_bad++; $display("FAIL coll_present: valid=%b idx=%0d, required 1/5", fp_out_valid, fp_out_idx); end
    out_ready = 1'b1; req_in = 32'h0000_0020;
    step();
    out_ready = 1'b0; req_in = '0;
    n_cmp++; if (fp_pending !== 32'h0000_0020 || fp_dup !== 1'b0 || fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL coll_setwins: pending=%h dup=%b valid=%b, required 00000020/0/0", fp_pending, fp_dup, fp_out_valid); end
    step();
    n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== 5'd5) begin
      n_bad++; $display("FAIL coll_represent: valid=%b idx=%0d, required 1/5", fp_out_valid, fp_out_idx); end
    req_in = 32'h0000_0080;
    step();
    n_cmp++; if (fp_dup !== 1'b0 || fp_pending !== 32'h0000_00A0) begin
      n_bad++; $display("FAIL dup_first: dup=%b pending=%h, required 0/000000a0", fp_dup, fp_pending); end
    step();
    req_in = '0;
    n_cmp++; if (fp_dup !== 1'b1) begin
      n_bad++; $display("FAIL dup_pulse: dup=%b, required 1", fp_dup); end
    step();
    n_cmp++; if (fp_dup !== 1'b0) begin
      n_bad++; $display("FAIL dup_clear: dup=%b, required 0", fp_dup); end
  endtask

  task automatic test_en_clr();
    do_reset();
    en = 1'b1; req_in = 32'h0000_00F0;
    step();
    req_in = '0;
    step();
    en = 1'b0; req_in = 32'hFFFF_FFFF;
    step();
    n_cmp++; if (fp_pending !== 32'h0000_00F0 || fp_dup !== 1'b0 || fp_out_idx !== 5'd4 || fp_out_valid !== 1'b1) begin
      n_bad++; $display("FAIL en_gate: pending=%h dup=%b idx=%0d valid=%b, required 000000f0/0/4/1", fp_pending, fp_dup, fp_out_idx, fp_out_valid); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (fp_pending !== 32'h0000_00E0 || fp_out_idx !== 5'd5) begin
      n_bad++; $display("FAIL en_drain: pending=%h idx=%0d, required 000000e0/5", fp_pending, fp_out_idx); end
    en = 1'b1; clr_all = 1'b1; req_in = 32'h0000_0002;
    step();
    clr_all = 1'b0; req_in = '0; out_ready = 1'b0;
    n_cmp++; if (fp_pending !== 32'h0 || fp_out_valid !== 1'b0 || fp_dup !== 1'b0) begin
      n_bad++; $display("FAIL clr_all: pending=%h valid=%b dup=%b, required 0/0/0", fp_pending, fp_out_valid, fp_dup); end
    step();
    n_cmp++; if (fp_pending !== 32'h0 || fp_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL clr_after: pending=%h valid=%b, required 0/0", fp_pending, fp_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    logic [4:0] last_f, last_r;
    logic was_stall;
    do_reset();
    en = 1'b1; req_in = 32'h0008_0000;
    step();
    req_in = '0;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_in = 32'hFFFF_FFFF;
    step();
    req_in = '0;
    step();
    for (int i = 0; i < 32; i++) q_f.push_back(i[4:0]);
    for (int i = 0; i < 32; i++) q_r.push_back(5'(i + 20));
    out_ready = 1'b1;
    for (int c = 0; c < 200 && (q_f.size() > 0 || q_r.size() > 0); c++) begin
      if (out_ready && q_f.size() > 0) begin
        e = q_f.pop_front();
        n_cmp++; if (fp_out_valid !== 1'b1 || fp_out_idx !== e) begin
          n_bad++; $display("FAIL drain_fp: valid=%b idx=%0d, required 1/%0d", fp_out_valid, fp_out_idx, e); end
      end
      if (out_ready && q_r.size() > 0) begin
        e = q_r.pop_front();
        n_cmp++; if (rr_out_valid !== 1'b1 || rr_out_idx !== e) begin
          n_bad++; $display("FAIL drain_rr: valid=%b idx=%0d, required 1/%0d", rr_out_valid, rr_out_idx, e); end
      end
      last_f = fp_out_idx; last_r = rr_out_idx; was_stall = !out_ready;
      step();
      if (was_stall) begin
        n_cmp++; if (fp_out_idx !== last_f || rr_out_idx !== last_r) begin
          n_bad++; $display("FAIL drain_stall: idx fp=%0d rr=%0d, required %0d/%0d", fp_out_idx, rr_out_idx, last_f, last_r); end
      end
      out_ready = !out_ready;
    end
    n_cmp++; if (q_f.size() != 0 || q_r.size() != 0) begin
      n_bad++; $display("FAIL drain_timeout: left fp=%0d rr=%0d, required 0/0", q_f.size(), q_r.size()); end
    n_cmp++; if (fp_out_valid !== 1'b0 || rr_out_valid !== 1'b0 || fp_pending !== 32'h0 || rr_pending !== 32'h0) begin
      n_bad++; $display("FAIL drain_end: valid fp=%b rr=%b pending fp=%h rr=%h, required all zero", fp_out_valid, rr_out_valid, fp_pending, rr_pending); end
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; en = 1'b0; req_in = '0; clr_all = 1'b0; out_ready = 1'b0;
    step();
    step();
    test_reset();
    test_single();
    test_fixed_burst();
    test_round_robin();
    test_collision();
    test_en_clr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pending_event_encoder.md
Name: pending_event_encoder

Overview:
- Reverse direction of the 5-to-32 one-hot decoder used for register-file write selects.
- Latches up to 32 sticky request lines into a pending vector.
- Encodes one pending request at a time into a 5-bit index and presents it on a valid/ready handshake.
- Clears each pending bit when its index is accepted; used for interrupt/event dispatch into the processor.

Parameters:
- ROUND_ROBIN, default 0: 0 = fixed priority, lowest index wins; 1 = rotating priority, search starts at last granted index + 1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  capture enable for req_in; 0 = req_in ignored
- req_in  input  32  request pulses; bit i sets pending[i]
- clr_all  input  1  synchronous flush of all pending state and output
- out_ready  input  1  consumer accepts out_idx this cycle
- out_valid  output  1  out_idx holds a valid pending index
- out_idx  output  5  encoded index of the presented request
- pending  output  32  registered pending vector
- dup  output  1  one-cycle pulse: a request hit an already-pending bit

Behaviour:
- Reset: the only reset is the asynchronous active-high `reset`. On assertion, pending=0, out_valid=0, out_idx=0, dup=0, rotate pointer=0, state=EMPTY.
- Capture:
  - set = req_in & {32{en}}.
  - clear = one-hot(out_idx) when out_valid & out_ready, else 0.
  - pending_next = (pending & ~clear) | set.
  - Set wins over clear on the same bit: a re-request during acceptance stays pending.
- Selection:
  - Combinational search over cand = pending & ~clear.
  - Uses only the registered pending vector; this cycle's set bits are not visible to selection.
  - Fixed mode: lowest set index.
  - Round-robin mode: first set index at or above ptr, wrapping 31->0.
- State machine, 2 states (EMPTY, VALID):
  - EMPTY: if cand != 0, load out_idx=sel, out_valid=1, go VALID. Else stay.
  - VALID, out_ready=0: out_idx and out_valid held stable (no change permitted while stalled).
  - VALID, out_ready=1: if cand != 0, load the next sel (back-to-back, one per cycle); else out_valid=0, go EMPTY.
  - On each accept in round-robin mode: ptr <= out_idx+1 (5-bit wrap, 31 -> 0).
- Latency: req_in at edge t -> pending at t+1 -> out_valid/out_idx at t+2 when EMPTY.
- Throughput: 1 index/cycle while out_ready=1 and cand nonzero.
- dup: registered; dup <= |(set & pending & ~clear).
- clr_all:
  - Next cycle: pending=0, out_valid=0, state=EMPTY, dup=0, ptr unchanged.
  - Overrides same-cycle req_in and accept; no clear-bit side effects.
- en=0: no capture; output continues draining existing pending bits.
- out_ready while out_valid=0: ignored.
- Reset mid-transfer: immediate return to reset values; nothing retained.
- All 32 bits pending:
  - Fixed mode drains 0..31 in order.
  - Round-robin mode drains from ptr upward with wrap.

Decomposition:
- Shared package holds:
  - N_REQ=32, IDX_W=5.
  - State encoding: EMPTY=1'b0, VALID=1'b1.
- Sub-module pick_encoder_32to5, combinational:
  - Inputs: cand[31:0], base[4:0], rr.
  - Outputs: idx[4:0], any.
  - Implemented as rotate, lowest-set encode, rotate back. Instantiated once.
- Top-level holds the pending register, state register, ptr and dup.

Test Plan:
- Reset/single request: assert reset mid-run -> all outputs 0 immediately. Then req_in=32'h0000_0100 for one cycle with en=1, out_ready=0 -> out_valid=1, out_idx=8 two edges later, held for 5 stalled cycles. out_ready=1 -> pending[8]=0, out_valid drops next cycle.
- Fixed priority burst: ROUND_ROBIN=0, req_in=32'h8000_0015, out_ready=1 constant -> out_idx sequence 0,2,4,31 on consecutive cycles, then out_valid=0.
- Round robin: ROUND_ROBIN=1, pending bits {3,10} after grant of 10 (ptr=11) -> next out_idx=3. Re-request bit 10 -> granted after 3, then wraps correctly at 31->0.
- Set vs clear collision: while out_idx=5 accepted, req_in[5]=1 the same cycle -> pending[5] remains 1, index 5 re-presented, dup=0. Request bit 7 while already pending -> dup pulses 1 for exactly one cycle.
- en gating and clr_all: en=0 with req_in=32'hFFFF_FFFF -> pending unchanged. With pending=32'h0000_00F0 and out_valid=1, assert clr_all together with req_in[1] -> next cycle pending=0, out_valid=0.
- Full drain: all 32 bits pending, out_ready toggling 1/0 every cycle -> each index 0..31 emitted exactly once, no index skipped or duplicated, out_idx stable on stalled cycles.
